// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction word encoder.
// Packs opcode, registers, funct fields and a compact immediate into one word.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_Valid / o_Ready       request handshake
//   i_Opcode, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Immediate
//                           request fields (compact sign-extended immediate)
//   o_Valid / i_Ready       output handshake
//   o_Instruction, o_Error  encoded word (zero on error), reject flag
//   o_EncCount, o_ErrCount  handed-off encodes (wrap) / rejects (saturate)

package instr_encoder_pkg;
    typedef logic [31:0] data_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        F_R, F_I, F_S, F_B, F_U, F_J, F_BAD
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [19:0] imm;
        fmt_e        fmt;
        logic        err;
    } s1_t;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [6:0]       i_Opcode,
    input  logic [4:0]       i_Rd,
    input  logic [4:0]       i_Rs1,
    input  logic [4:0]       i_Rs2,
    input  logic [2:0]       i_Funct3,
    input  logic [6:0]       i_Funct7,
    input  data_t            i_Immediate,
    output logic             o_Valid,
    input  logic             i_Ready,
    output data_t            o_Instruction,
    output logic             o_Error,
    output logic [CNT_W-1:0] o_EncCount,
    output logic [ERR_W-1:0] o_ErrCount
);

    logic  s1_v, s2_v;
    logic  s1_adv, s2_adv, accept, fire;
    fmt_e  fmt_d;
    logic  fits12, fits20, range_ok;
    s1_t   s1_d, s1_q;
    data_t word;

    assign s2_adv  = !s2_v || i_Ready;
    assign s1_adv  = !s1_v || s2_adv;
    assign o_Ready = s1_adv;
    assign accept  = i_Valid && o_Ready;
    assign fire    = s2_v && i_Ready;
    assign o_Valid = s2_v;

    // Upper bits must be a pure sign extension of the field's top bit.
    assign fits12 = (&i_Immediate[31:11]) || !(|i_Immediate[31:11]);
    assign fits20 = (&i_Immediate[31:19]) || !(|i_Immediate[31:19]);

    always_comb begin
        fmt_d = F_BAD;
        unique case (1'b1)
            i_Opcode == OP_OP:     fmt_d = F_R;
            i_Opcode == OP_IMM,
            i_Opcode == OP_LOAD,
            i_Opcode == OP_JALR:   fmt_d = F_I;
            i_Opcode == OP_STORE:  fmt_d = F_S;
            i_Opcode == OP_BRANCH: fmt_d = F_B;
            i_Opcode == OP_LUI,
            i_Opcode == OP_AUIPC:  fmt_d = F_U;
            i_Opcode == OP_JAL:    fmt_d = F_J;
            default:               fmt_d = F_BAD;
        endcase
    end

    always_comb begin
        range_ok = 1'b0;
        unique case (fmt_d)
            F_R:           range_ok = 1'b1;
            F_I, F_S, F_B: range_ok = fits12;
            F_U, F_J:      range_ok = fits20;
            default:       range_ok = 1'b0;
        endcase
    end

    always_comb begin
        s1_d        = '0;
        s1_d.opcode = i_Opcode;
        s1_d.rd     = i_Rd;
        s1_d.rs1    = i_Rs1;
        s1_d.rs2    = i_Rs2;
        s1_d.funct3 = i_Funct3;
        s1_d.funct7 = i_Funct7;
        s1_d.imm    = i_Immediate[19:0];
        s1_d.fmt    = fmt_d;
        s1_d.err    = !range_ok;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_adv) begin
            s1_v <= accept;
            if (accept) s1_q <= s1_d;
        end
    end

    always_comb begin
        word      = '0;
        word[6:0] = s1_q.opcode;
        unique case (s1_q.fmt)
            F_R: begin
                word[31:25] = s1_q.funct7;
                word[24:20] = s1_q.rs2;
                word[19:15] = s1_q.rs1;
                word[14:12] = s1_q.funct3;
                word[11:7]  = s1_q.rd;
            end
            F_I: begin
                word[31:20] = s1_q.imm[11:0];
                word[19:15] = s1_q.rs1;
                word[14:12] = s1_q.funct3;
                word[11:7]  = s1_q.rd;
            end
            F_S: begin
                word[31:25] = s1_q.imm[11:5];
                word[24:20] = s1_q.rs2;
                word[19:15] = s1_q.rs1;
                word[14:12] = s1_q.funct3;
                word[11:7]  = s1_q.imm[4:0];
            end
            F_B: begin
                word[31]    = s1_q.imm[11];
                word[30:25] = s1_q.imm[9:4];
                word[24:20] = s1_q.rs2;
                word[19:15] = s1_q.rs1;
                word[14:12] = s1_q.funct3;
                word[11:8]  = s1_q.imm[3:0];
                word[7]     = s1_q.imm[10];
            end
            F_U: begin
                word[31:12] = s1_q.imm[19:0];
                word[11:7]  = s1_q.rd;
            end
            F_J: begin
                word[31]    = s1_q.imm[19];
                word[30:21] = s1_q.imm[9:0];
                word[20]    = s1_q.imm[10];
                word[19:12] = s1_q.imm[18:11];
                word[11:7]  = s1_q.rd;
            end
            default: word = '0;
        endcase
        if (s1_q.err) word = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_v          <= 1'b0;
            o_Instruction <= '0;
            o_Error       <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                o_Instruction <= word;
                o_Error       <= s1_q.err;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_EncCount <= '0;
            o_ErrCount <= '0;
        end else if (fire) begin
            if (!o_Error) begin
                o_EncCount <= o_EncCount + 1'b1;
            end else if (o_ErrCount != '1) begin
                o_ErrCount <= o_ErrCount + 1'b1;
            end
        end
    end

endmodule
